// File: rtl/int32_issue_arbiter.sv
// Round-robin issue arbiter sharing one int32 core among NUM_REQ requesters, with a tagged response FIFO and a halt/drain handshake.
// Define INT32_ARB_PERF_EN to add saturating perf counters (perf_issued, perf_credit_stall, perf_err).
module int32_issue_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int OPCODE_WIDTH = 8,
   parameter int TAG_WIDTH    = 5,
   parameter int RSP_DEPTH    = 4,
   localparam int ID_W        = $clog2(NUM_REQ)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ*OPCODE_WIDTH-1:0]   req_opcode,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_operand_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_operand_b,
   input  logic [NUM_REQ-1:0]                req_use_imm,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_imm,
   input  logic [NUM_REQ*TAG_WIDTH-1:0]      req_tag,
   output logic                              core_valid_instruction,
   output logic [OPCODE_WIDTH-1:0]           core_opcode,
   output logic [DATA_WIDTH-1:0]             core_operand_a,
   output logic [DATA_WIDTH-1:0]             core_operand_b,
   output logic                              core_use_immediate,
   output logic [DATA_WIDTH-1:0]             core_immediate_value,
   input  logic                              core_result_valid,
   input  logic [DATA_WIDTH-1:0]             core_result_out,
   input  logic                              core_carry_out,
   input  logic                              core_overflow_out,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [ID_W-1:0]                   rsp_id,
   output logic [TAG_WIDTH-1:0]              rsp_tag,
   output logic [DATA_WIDTH-1:0]             rsp_data,
   output logic                              rsp_carry,
   output logic                              rsp_overflow,
   output logic                              rsp_err,
   input  logic                              halt_req,
   output logic                              halt_ack
`ifdef INT32_ARB_PERF_EN
  ,output logic [31:0]                       perf_issued,
   output logic [31:0]                       perf_credit_stall,
   output logic [31:0]                       perf_err
`endif
);

   localparam int AW    = $clog2(RSP_DEPTH);
   localparam int CNT_W = AW + 1;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   typedef struct packed {
      logic [ID_W-1:0]       id;
      logic [TAG_WIDTH-1:0]  tag;
      logic [DATA_WIDTH-1:0] data;
      logic                  carry;
      logic                  overflow;
      logic                  err;
   } rsp_t;

   state_t                state;
   logic [ID_W-1:0]       rr_ptr;
   logic [ID_W-1:0]       winner;
   logic [ID_W-1:0]       scan_idx;
   logic                  grant_found;
   logic                  credit_ok;
   logic                  issue;
   int                    win_i;
   logic [CNT_W:0]        credit_sum;

   logic                  inflight_valid;
   logic [ID_W-1:0]       inflight_id;
   logic [TAG_WIDTH-1:0]  inflight_tag;

   rsp_t                  mem [RSP_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CNT_W-1:0]      fifo_count;
   rsp_t                  push_entry;
   rsp_t                  head;
   rsp_t                  last_rsp;
   rsp_t                  shown;
   logic                  push;
   logic                  pop;

   // The in-flight op already owns a FIFO slot, so it counts against credit.
   assign credit_sum = {1'b0, fifo_count} + (CNT_W+1)'(inflight_valid);
   assign credit_ok  = credit_sum < (CNT_W+1)'(RSP_DEPTH);

   // NOTE: blocking assignments here model combinational flow; scan_idx is rewritten every iteration, so order matters.
   always_comb begin
      grant_found = 1'b0;
      winner      = '0;
      scan_idx    = rr_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_found && req_valid[scan_idx]) begin
            grant_found = 1'b1;
            winner      = scan_idx;
         end
         scan_idx = (scan_idx == ID_W'(NUM_REQ-1)) ? '0 : scan_idx + 1'b1;
      end
   end

   assign issue = rst && (state == ST_RUN) && credit_ok && grant_found;
   assign win_i = int'(winner);

   always_comb begin
      req_ready              = '0;
      core_valid_instruction = 1'b0;
      core_opcode            = '0;
      core_operand_a         = '0;
      core_operand_b         = '0;
      core_use_immediate     = 1'b0;
      core_immediate_value   = '0;
      if (issue) begin
         req_ready[winner]      = 1'b1;
         core_valid_instruction = 1'b1;
         core_opcode            = req_opcode[win_i*OPCODE_WIDTH +: OPCODE_WIDTH];
         core_operand_a         = req_operand_a[win_i*DATA_WIDTH +: DATA_WIDTH];
         core_operand_b         = req_operand_b[win_i*DATA_WIDTH +: DATA_WIDTH];
         core_use_immediate     = req_use_imm[winner];
         core_immediate_value   = req_imm[win_i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign push = inflight_valid;
   assign pop  = rsp_valid && rsp_ready;

   always_comb begin
      push_entry     = '0;
      push_entry.id  = inflight_id;
      push_entry.tag = inflight_tag;
      if (core_result_valid) begin
         push_entry.data     = core_result_out;
         push_entry.carry    = core_carry_out;
         push_entry.overflow = core_overflow_out;
      end else begin
         push_entry.err = 1'b1;
      end
   end

   // NOTE: storage is left unreset; fifo_count gates visibility and last_rsp supplies the reset-time outputs.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_entry;
   end

   assign head      = mem[rd_ptr];
   assign rsp_valid = (fifo_count != '0);
   assign shown     = rsp_valid ? head : last_rsp;

   assign rsp_id       = shown.id;
   assign rsp_tag      = shown.tag;
   assign rsp_data     = shown.data;
   assign rsp_carry    = shown.carry;
   assign rsp_overflow = shown.overflow;
   assign rsp_err      = shown.err;

   // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         fifo_count     <= '0;
         last_rsp       <= '0;
         inflight_valid <= 1'b0;
         inflight_id    <= '0;
         inflight_tag   <= '0;
         rr_ptr         <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            last_rsp <= head;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         inflight_valid <= issue;
         if (issue) begin
            inflight_id  <= winner;
            inflight_tag <= req_tag[win_i*TAG_WIDTH +: TAG_WIDTH];
            rr_ptr       <= (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_RUN;
         halt_ack <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (halt_req) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (!halt_req) begin
                  state <= ST_RUN;
               end else if (!inflight_valid && fifo_count == '0) begin
                  state    <= ST_HALTED;
                  halt_ack <= 1'b1;
               end
            end
            ST_HALTED: begin
               if (!halt_req) begin
                  state    <= ST_RUN;
                  halt_ack <= 1'b0;
               end
            end
            default: begin
               state    <= ST_RUN;
               halt_ack <= 1'b0;
            end
         endcase
      end
   end

`ifdef INT32_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_issued       <= '0;
         perf_credit_stall <= '0;
         perf_err          <= '0;
      end else begin
         if (issue && perf_issued != '1)
            perf_issued <= perf_issued + 32'd1;
         if ((|req_valid) && state == ST_RUN && !credit_ok && perf_credit_stall != '1)
            perf_credit_stall <= perf_credit_stall + 32'd1;
         if (push && !core_result_valid && perf_err != '1)
            perf_err <= perf_err + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_int32_issue_arbiter.sv
// Directed bench for int32_issue_arbiter: a small behavioural int32 core answers one cycle after each issue.
module tb_int32_issue_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DW      = 32;
   localparam int OW      = 8;
   localparam int TW      = 5;

   logic                  clk;
   logic                  rst;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*OW-1:0] req_opcode;
   logic [NUM_REQ*DW-1:0] req_operand_a;
   logic [NUM_REQ*DW-1:0] req_operand_b;
   logic [NUM_REQ-1:0]    req_use_imm;
   logic [NUM_REQ*DW-1:0] req_imm;
   logic [NUM_REQ*TW-1:0] req_tag;
   logic                  core_valid_instruction;
   logic [OW-1:0]         core_opcode;
   logic [DW-1:0]         core_operand_a;
   logic [DW-1:0]         core_operand_b;
   logic                  core_use_immediate;
   logic [DW-1:0]         core_immediate_value;
   logic                  core_result_valid;
   logic [DW-1:0]         core_result_out;
   logic                  core_carry_out;
   logic                  core_overflow_out;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [1:0]            rsp_id;
   logic [TW-1:0]         rsp_tag;
   logic [DW-1:0]         rsp_data;
   logic                  rsp_carry;
   logic                  rsp_overflow;
   logic                  rsp_err;
   logic                  halt_req;
   logic                  halt_ack;
`ifdef INT32_ARB_PERF_EN
   logic [31:0]           perf_issued;
   logic [31:0]           perf_credit_stall;
   logic [31:0]           perf_err;
`endif

   int checks = 0;
   int errors = 0;
   int outstanding = 0;

   int         t2_id    [5] = '{0, 1, 2, 3, 0};
   logic [3:0] t2_grant [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [3:0] t3_grant [8] = '{4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
   int         t3_id    [5] = '{1, 0, 1, 0, 1};
   int         t3_tag   [5] = '{8, 1, 10, 3, 15};
   int         t3_data  [5] = '{2000, 1001, 2002, 1003, 2007};

   int32_issue_arbiter dut (
      .clk                    (clk),
      .rst                    (rst),
      .req_valid              (req_valid),
      .req_ready              (req_ready),
      .req_opcode             (req_opcode),
      .req_operand_a          (req_operand_a),
      .req_operand_b          (req_operand_b),
      .req_use_imm            (req_use_imm),
      .req_imm                (req_imm),
      .req_tag                (req_tag),
      .core_valid_instruction (core_valid_instruction),
      .core_opcode            (core_opcode),
      .core_operand_a         (core_operand_a),
      .core_operand_b         (core_operand_b),
      .core_use_immediate     (core_use_immediate),
      .core_immediate_value   (core_immediate_value),
      .core_result_valid      (core_result_valid),
      .core_result_out        (core_result_out),
      .core_carry_out         (core_carry_out),
      .core_overflow_out      (core_overflow_out),
      .rsp_valid              (rsp_valid),
      .rsp_ready              (rsp_ready),
      .rsp_id                 (rsp_id),
      .rsp_tag                (rsp_tag),
      .rsp_data               (rsp_data),
      .rsp_carry              (rsp_carry),
      .rsp_overflow           (rsp_overflow),
      .rsp_err                (rsp_err),
      .halt_req               (halt_req),
      .halt_ack               (halt_ack)
`ifdef INT32_ARB_PERF_EN
     ,.perf_issued            (perf_issued),
      .perf_credit_stall      (perf_credit_stall),
      .perf_err               (perf_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural core: opcode 0x01 is ADD (operand b or immediate), anything else is undefined.
   logic          p_valid;
   logic [OW-1:0] p_op;
   logic [DW-1:0] p_a;
   logic [DW-1:0] p_b;
   logic [DW:0]   p_sum;

   always @(posedge clk) begin
      p_valid <= core_valid_instruction;
      p_op    <= core_opcode;
      p_a     <= core_operand_a;
      p_b     <= core_use_immediate ? core_immediate_value : core_operand_b;
   end

   assign p_sum             = {1'b0, p_a} + {1'b0, p_b};
   assign core_result_valid = p_valid && (p_op == 8'h01);
   assign core_result_out   = core_result_valid ? p_sum[DW-1:0] : '0;
   assign core_carry_out    = core_result_valid && p_sum[DW];
   assign core_overflow_out = core_result_valid && (p_a[DW-1] == p_b[DW-1]) && (p_sum[DW-1] != p_a[DW-1]);

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   task automatic chk_rsp(input string n, input logic [1:0] id, input logic [TW-1:0] tag,
                          input logic [DW-1:0] data, input logic c, input logic o, input logic e);
      check({n, "_valid"}, 64'(rsp_valid), 64'(1'b1));
      check({n, "_id"},    64'(rsp_id),    64'(id));
      check({n, "_tag"},   64'(rsp_tag),   64'(tag));
      check({n, "_data"},  64'(rsp_data),  64'(data));
      check({n, "_carry"}, 64'(rsp_carry), 64'(c));
      check({n, "_ovf"},   64'(rsp_overflow), 64'(o));
      check({n, "_err"},   64'(rsp_err),   64'(e));
   endtask

   task automatic set_req(input int i, input logic [OW-1:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic imm_sel, input logic [DW-1:0] imm,
                          input logic [TW-1:0] tag);
      req_valid[i]            = 1'b1;
      req_opcode[i*OW +: OW]  = op;
      req_operand_a[i*DW +: DW] = a;
      req_operand_b[i*DW +: DW] = b;
      req_use_imm[i]          = imm_sel;
      req_imm[i*DW +: DW]     = imm;
      req_tag[i*TW +: TW]     = tag;
   endtask

   task automatic clr_all();
      req_valid     = '0;
      req_opcode    = '0;
      req_operand_a = '0;
      req_operand_b = '0;
      req_use_imm   = '0;
      req_imm       = '0;
      req_tag       = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accepted-but-unpopped ops must never exceed the FIFO depth.
   always @(posedge clk) begin
      if (!rst) outstanding <= 0;
      else outstanding <= outstanding + int'((req_valid & req_ready) != '0) - int'(rsp_valid && rsp_ready);
   end

   always @(negedge clk) begin
      if (rst === 1'b1) check("credit_bound", 64'(outstanding <= 4), 64'd1);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b0;
      rsp_ready = 1'b0;
      halt_req  = 1'b0;
      clr_all();
      repeat (2) @(posedge clk);
      #1;

      // Reset state, with all requesters asserting valid.
      req_valid = '1;
      #1;
      check("rst_req_ready",  64'(req_ready), 64'd0);
      check("rst_core_valid", 64'(core_valid_instruction), 64'd0);
      check("rst_rsp_valid",  64'(rsp_valid), 64'd0);
      check("rst_halt_ack",   64'(halt_ack),  64'd0);
      check("rst_rsp_data",   64'(rsp_data),  64'd0);
      check("rst_rsp_err",    64'(rsp_err),   64'd0);
      clr_all();
      rst = 1'b1;

      // Test 1: requester 2 ADD 5+7 tag 3.
      rsp_ready = 1'b1;
      set_req(2, 8'h01, 32'd5, 32'd7, 1'b0, 32'd0, 5'd3);
      #1;
      check("t1_ready",  64'(req_ready), 64'b0100);
      check("t1_cvalid", 64'(core_valid_instruction), 64'd1);
      check("t1_cop",    64'(core_opcode), 64'h01);
      check("t1_ca",     64'(core_operand_a), 64'd5);
      check("t1_cb",     64'(core_operand_b), 64'd7);
      check("t1_cimm",   64'(core_use_immediate), 64'd0);
      tick();
      clr_all();
      #1;
      check("t1_t1_rsp_valid", 64'(rsp_valid), 64'd0);
      check("t1_t1_ready",     64'(req_ready), 64'd0);
      check("t1_t1_cvalid",    64'(core_valid_instruction), 64'd0);
      check("t1_t1_cop",       64'(core_opcode), 64'd0);
      tick();
      #1;
      chk_rsp("t1", 2'd2, 5'd3, 32'd12, 1'b0, 1'b0, 1'b0);
      tick();
      #1;
      check("t1_empty",     64'(rsp_valid), 64'd0);
      check("t1_hold_data", 64'(rsp_data),  64'd12);
      check("t1_hold_tag",  64'(rsp_tag),   64'd3);
      tick();

      // Pointer wrap from 3 with an immediate operand: 100 + imm 23.
      set_req(3, 8'h01, 32'd100, 32'd0, 1'b1, 32'd23, 5'd7);
      #1;
      check("t1b_ready", 64'(req_ready), 64'b1000);
      check("t1b_cimm",  64'(core_use_immediate), 64'd1);
      check("t1b_cimmv", 64'(core_immediate_value), 64'd23);
      tick();
      clr_all();
      tick();
      #1;
      chk_rsp("t1b", 2'd3, 5'd7, 32'd123, 1'b0, 1'b0, 1'b0);
      tick();

      // Test 2: all four requesters valid from pointer 0.
      for (int c = 0; c < 8; c++) begin
         if (c < 5) begin
            for (int i = 0; i < NUM_REQ; i++)
               set_req(i, 8'h01, 32'(i + 1), 32'd100, 1'b0, 32'd0, 5'(10 + i));
         end else begin
            clr_all();
         end
         #1;
         if (c < 5) check($sformatf("t2_grant%0d", c), 64'(req_ready), 64'(t2_grant[c]));
         if (c >= 2 && c < 7)
            chk_rsp($sformatf("t2_rsp%0d", c - 2), 2'(t2_id[c-2]), 5'(10 + t2_id[c-2]),
                    32'(101 + t2_id[c-2]), 1'b0, 1'b0, 1'b0);
         if (c == 7) check("t2_empty", 64'(rsp_valid), 64'd0);
         tick();
      end

      // Test 3: backpressure, requesters 0 and 1 stream with rsp_ready low, then drain.
      for (int k = 0; k < 12; k++) begin
         rsp_ready = (k >= 6);
         if (k <= 7) begin
            set_req(0, 8'h01, 32'(1000 + k), 32'd0, 1'b0, 32'd0, 5'(k));
            set_req(1, 8'h01, 32'(2000 + k), 32'd0, 1'b0, 32'd0, 5'(8 + k));
         end else begin
            clr_all();
         end
         #1;
         if (k <= 7) check($sformatf("t3_grant%0d", k), 64'(req_ready), 64'(t3_grant[k]));
         if (k == 5) chk_rsp("t3_stalled_head", 2'd1, 5'd8, 32'd2000, 1'b0, 1'b0, 1'b0);
         if (k >= 6 && k <= 10)
            chk_rsp($sformatf("t3_rsp%0d", k - 6), 2'(t3_id[k-6]), 5'(t3_tag[k-6]),
                    32'(t3_data[k-6]), 1'b0, 1'b0, 1'b0);
         if (k == 11) check("t3_empty", 64'(rsp_valid), 64'd0);
         tick();
      end

      // Test 4: undefined opcode, then an add that sets carry and overflow.
      rsp_ready = 1'b1;
      set_req(0, 8'hFF, 32'd1, 32'd2, 1'b0, 32'd0, 5'd9);
      #1;
      check("t4_ready0", 64'(req_ready), 64'b0001);
      tick();
      clr_all();
      set_req(1, 8'h01, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0, 5'd4);
      #1;
      check("t4_ready1", 64'(req_ready), 64'b0010);
      tick();
      clr_all();
      #1;
      chk_rsp("t4_err", 2'd0, 5'd9, 32'd0, 1'b0, 1'b0, 1'b1);
      tick();
      #1;
      chk_rsp("t4_cv", 2'd1, 5'd4, 32'd0, 1'b1, 1'b1, 1'b0);
      tick();
      #1;
      check("t4_empty", 64'(rsp_valid), 64'd0);
      tick();

      // Test 5: halt with one op in flight and two queued.
      rsp_ready = 1'b0;
      set_req(2, 8'h01, 32'd50, 32'd1, 1'b0, 32'd0, 5'd1);
      set_req(3, 8'h01, 32'd60, 32'd2, 1'b0, 32'd0, 5'd2);
      #1;
      check("t5_h0_ready", 64'(req_ready), 64'b0100);
      tick();
      set_req(2, 8'h01, 32'd50, 32'd1, 1'b0, 32'd0, 5'd3);
      #1;
      check("t5_h1_ready", 64'(req_ready), 64'b1000);
      tick();
      halt_req = 1'b1;
      #1;
      check("t5_h2_ready", 64'(req_ready), 64'b0100);
      check("t5_h2_ack",   64'(halt_ack),  64'd0);
      tick();
      #1;
      check("t5_h3_ready", 64'(req_ready), 64'd0);
      check("t5_h3_ack",   64'(halt_ack),  64'd0);
      tick();
      rsp_ready = 1'b1;
      #1;
      chk_rsp("t5_pop0", 2'd2, 5'd1, 32'd51, 1'b0, 1'b0, 1'b0);
      check("t5_h4_ack",   64'(halt_ack),  64'd0);
      check("t5_h4_ready", 64'(req_ready), 64'd0);
      tick();
      #1;
      chk_rsp("t5_pop1", 2'd3, 5'd2, 32'd62, 1'b0, 1'b0, 1'b0);
      check("t5_h5_ack", 64'(halt_ack), 64'd0);
      tick();
      #1;
      chk_rsp("t5_pop2", 2'd2, 5'd3, 32'd51, 1'b0, 1'b0, 1'b0);
      check("t5_h6_ack", 64'(halt_ack), 64'd0);
      tick();
      #1;
      check("t5_h7_rsp_valid", 64'(rsp_valid), 64'd0);
      check("t5_h7_ack",       64'(halt_ack),  64'd0);
      check("t5_h7_ready",     64'(req_ready), 64'd0);
      tick();
      #1;
      check("t5_h8_ack",   64'(halt_ack),  64'd1);
      check("t5_h8_ready", 64'(req_ready), 64'd0);
      tick();
      halt_req = 1'b0;
      #1;
      check("t5_h9_ack",   64'(halt_ack),  64'd1);
      check("t5_h9_ready", 64'(req_ready), 64'd0);
      tick();
      #1;
      check("t5_h10_ack",   64'(halt_ack),  64'd0);
      check("t5_h10_ready", 64'(req_ready), 64'b1000);
      tick();
      clr_all();
      tick();
      #1;
      chk_rsp("t5_resume", 2'd3, 5'd2, 32'd62, 1'b0, 1'b0, 1'b0);
      tick();

      // Test 6: reset one cycle after an issue discards it and returns the pointer to 0.
      set_req(1, 8'h01, 32'd7, 32'd8, 1'b0, 32'd0, 5'd5);
      #1;
      check("t6_r0_ready", 64'(req_ready), 64'b0010);
      tick();
      rst = 1'b0;
      clr_all();
      set_req(0, 8'h01, 32'd3, 32'd4, 1'b0, 32'd0, 5'd6);
      set_req(2, 8'h01, 32'd9, 32'd9, 1'b0, 32'd0, 5'd11);
      #1;
      check("t6_r1_ready",     64'(req_ready), 64'd0);
      check("t6_r1_rsp_valid", 64'(rsp_valid), 64'd0);
      check("t6_r1_ack",       64'(halt_ack),  64'd0);
      tick();
      rst = 1'b1;
      #1;
      check("t6_r2_rsp_valid", 64'(rsp_valid), 64'd0);
      check("t6_r2_ready",     64'(req_ready), 64'b0001);
      tick();
      clr_all();
      #1;
      check("t6_r3_rsp_valid", 64'(rsp_valid), 64'd0);
      tick();
      #1;
      chk_rsp("t6_rsp", 2'd0, 5'd6, 32'd7, 1'b0, 1'b0, 1'b0);
      tick();
      #1;
      check("t6_empty", 64'(rsp_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/int32_issue_arbiter.md
Name: int32_issue_arbiter

Overview:
- Shares one int32 integer core among NUM_REQ requesters, for example warp-slot dispatch ports.
- Picks one requester per cycle by round-robin and drives the core's instruction inputs.
- Tracks the single in-flight op through the core's 1-cycle result latency and buffers results in a response FIFO tagged with requester id and tag.
- Provides a halt/drain handshake so the scheduler can quiesce the core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 32, operand/result width
- OPCODE_WIDTH, 8, opcode width
- TAG_WIDTH, 5, requester-supplied tag echoed on the response
- RSP_DEPTH, 4, response FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_opcode  in  NUM_REQ*OPCODE_WIDTH  flattened opcodes; requester i at slice i
- req_operand_a  in  NUM_REQ*DATA_WIDTH  flattened RS1
- req_operand_b  in  NUM_REQ*DATA_WIDTH  flattened RS2
- req_use_imm  in  NUM_REQ  immediate select
- req_imm  in  NUM_REQ*DATA_WIDTH  flattened immediate values
- req_tag  in  NUM_REQ*TAG_WIDTH  flattened tags
- core_valid_instruction  out  1  to core
- core_opcode, core_operand_a, core_operand_b, core_use_immediate, core_immediate_value  out  matching widths  to core
- core_result_valid  in  1  from core
- core_result_out  in  DATA_WIDTH  from core
- core_carry_out  in  1  from core
- core_overflow_out  in  1  from core
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts
- rsp_id  out  $clog2(NUM_REQ)  originating requester
- rsp_tag  out  TAG_WIDTH  echoed tag
- rsp_data  out  DATA_WIDTH  result
- rsp_carry  out  1  carry flag
- rsp_overflow  out  1  overflow flag
- rsp_err  out  1  undefined opcode (core returned no valid result)
- halt_req  in  1  level request to quiesce
- halt_ack  out  1  core idle, FIFO empty, no grants

Behaviour:
- Reset (rst=0 at posedge):
  - FSM=RUN, RR pointer=0, in-flight cleared, FIFO emptied.
  - All outputs 0; rsp_valid=0, halt_ack=0.
  - An op in flight at reset is discarded with no response.
- Grant (combinational):
  - Eligible when FSM=RUN and credit_ok.
  - credit_ok = (fifo_count + inflight_valid) < RSP_DEPTH.
  - Winner is the first asserted req_valid at or after the RR pointer, modulo NUM_REQ.
  - req_ready[winner]=1; all other req_ready bits are 0.
  - req_ready does not depend on rsp_ready in the same cycle; a pop does not free credit until the next cycle.
- Issue (same cycle T as the accepting handshake):
  - core_valid_instruction=1; core_* driven from the winner's slices.
  - When no issue occurs, core_valid_instruction=0 and the other core_* outputs are 0.
  - RR pointer updates to winner+1 (wrapping) at the end of T; it is unchanged when nothing issues.
- In-flight register (1 entry): set to {winner id, tag} at end of T; it may be reloaded by a new issue in the same cycle (back-to-back issue every cycle is allowed).
- Capture in cycle T+1 when in-flight is valid; push into the FIFO at end of T+1:
  - core_result_valid=1: push {id, tag, result, carry, overflow, err=0}.
  - core_result_valid=0: push {id, tag, data=0, carry=0, overflow=0, err=1}.
- Latency: request accepted in T → rsp_valid in T+2 when the FIFO was empty.
- FIFO:
  - Show-ahead; rsp_* reflect the head entry.
  - Pop when rsp_valid & rsp_ready.
  - Simultaneous push and pop at full or empty is legal; the count is unchanged.
  - Overflow cannot occur because credit_ok gates issue. The verification bench asserts this.
  - When rsp_valid=0, rsp_* hold their last values.
- FSM:
  - RUN → DRAIN when halt_req=1. In DRAIN, no grants.
  - DRAIN → HALTED when in-flight is empty and fifo_count=0.
  - In HALTED, halt_ack=1 and there are no grants.
  - HALTED → RUN when halt_req=0; halt_ack drops in the same cycle as that transition.
  - DRAIN → RUN directly if halt_req deasserts before the drain completes.
  - halt_req seen in the same cycle as a grant: the grant still issues (grant is evaluated on the registered FSM state); draining starts the next cycle.

Optional Feature:
- Macro name: INT32_ARB_PERF_EN.
- Defined: adds outputs perf_issued (32), perf_credit_stall (32) and perf_err (32), all cleared on reset and saturating at all-ones.
  - perf_issued increments per issue.
  - perf_credit_stall increments in each cycle where some req_valid=1, FSM=RUN and credit_ok=0.
  - perf_err increments per push with err=1.
- Undefined: those ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Basic add: requester 2 issues ADD 0x01, a=5, b=7, tag 3, rsp_ready=1 → rsp_valid at T+2 with id=2, tag=3, data=12, err=0.
2. Round-robin fairness: all 4 requesters hold valid with pointer=0 → grants 0,1,2,3,0 on consecutive cycles; 5 responses in order.
3. Backpressure and credit: rsp_ready=0, requesters 0 and 1 stream ops → exactly 4 accepts, then req_ready=0. Raising rsp_ready resumes issue one cycle after the first pop; no loss, order preserved.
4. Undefined opcode: opcode 0xFF, tag 9 → response with err=1, data=0, tag=9; FIFO unaffected otherwise.
5. Halt/drain: halt_req raised with 1 op in flight and 2 entries queued → no grants; halt_ack=1 only after the third pop. Dropping halt_req → halt_ack=0 and grants resume the next cycle.
6. Reset mid-op: assert rst=0 one cycle after an issue → no response appears; rsp_valid=0, pointer=0, req_ready resumes after reset releases.
